mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath: one instruction per 3-5 states, shared memory port, one ALU.
//  Sits beside the datapath. Takes opcode/funct from IR, ALU zero and memory ready; drives every mux select and write strobe.
//  Replaces the single-cycle CONTROL decoder when the datapath runs multi-cycle.
// PARAMETERS
//  STATE_W   4   width of state_out debug bus
// PORTS
//  clk        in   1  system clock, rising edge
//  nrst       in   1  asynchronous active-low reset
//  opcode     in   6  IR[31:26]
//  funct      in   6  IR[5:0]
//  alu_zero   in   1  ALU zero flag
//  mem_ready  in   1  memory completes the current access this cycle
//  pc_write   out  1  PC load strobe (branch condition already applied)
//  ir_write   out  1  IR load strobe
//  i_or_d     out  1  memory address: 0=PC, 1=ALUOut
//  mem_read   out  1  memory read request
//  mem_write  out  1  memory write request
//  reg_write  out  1  register bank write
//  reg_dst    out  2  00=rt, 01=rd, 10=r31
//  mem_to_reg out  2  00=ALUOut, 01=MDR, 10=PC (link)
//  alu_src_a  out  1  0=PC, 1=rs
//  alu_src_b  out  2  00=rt, 01=const 4, 10=signext, 11=signext<<2
//  alu_op     out  2  00=add, 01=sub, 10=funct-decoded, 11=opcode-decoded immediate op
//  pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs (jr)
//  illegal    out  1  sticky: unknown opcode/funct decoded
//  state_out  out  STATE_W  current state, debug
// BEHAVIOUR
//  - Reset: state<=FETCH asynchronously. While nrst=0 every output is 0 (strobes gated by nrst), illegal=0.
//    A reset mid-instruction aborts it. No partial write occurs after nrst falls.
//  - Moore selects. Strobes listed per state. Unlisted outputs are 0.
//  - FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=00, pc_source=00.
//    Hold until mem_ready=1. On that cycle ir_write=1 and pc_write=1 (PC+4), then go to DECODE.
//  - DECODE: src_a=0, src_b=11, alu_op=00 (branch target to ALUOut). Next state by opcode:
//    lw 100011 / sw 101011 ->MEM_ADDR | R 000000 ->R_EXEC | beq 000100 / bne 000101 ->BRANCH
//    j 000010 / jal 000011 ->JUMP | addi 001000, slti 001010, andi 001100, ori 001101 ->I_EXEC | other ->TRAP
//  - MEM_ADDR: src_a=1, src_b=10, alu_op=00. Next MEM_RD (lw) or MEM_WR (sw).
//  - MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
//  - MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Next FETCH.
//  - MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH. Strobe stays high while waiting.
//  - R_EXEC: src_a=1, src_b=00, alu_op=10.
//    If funct=001000 (jr): pc_source=11, pc_write=1, next FETCH. Otherwise next R_WB.
//  - R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Next FETCH.
//  - I_EXEC: src_a=1, src_b=10, alu_op=11. Next I_WB.
//  - I_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Next FETCH.
//  - BRANCH: src_a=1, src_b=00, alu_op=01, pc_source=01.
//    pc_write = alu_zero (beq) or !alu_zero (bne). Next FETCH.
//  - JUMP: pc_source=10, pc_write=1. For jal also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already +4). Next FETCH.
//  - TRAP: illegal=1, all strobes 0, stays here until reset.
//  - Unknown funct in R_EXEC (not add/sub/and/or/slt/jr) ->TRAP instead of R_WB.
//  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored. An unreachable state encoding returns to FETCH.
//  - CPI: lw 5, sw/R/I 4, beq/bne/j/jal/jr 3, each plus memory wait cycles.
// STRUCTURE
//  - mips_ctrl_pkg: opcode and funct constants, state encoding (4-bit localparams), alu_op / pc_source / reg_dst / mem_to_reg codes.
//    Shared with the ALU_CONTROL and datapath.
//  - Sub-module mips_ctrl_decode: combinational opcode/funct -> instruction class + legal flag. Feeds the DECODE/R_EXEC transitions.
//  - Top: state register (async clear), next-state logic, output decode, nrst gating.
// TESTING
//  1. Reset: hold nrst=0 for 3 clks with mem_ready=1 -> all outputs 0. Release -> state_out=FETCH, mem_read=1.
//  2. Fetch wait: mem_ready=0 for 4 clks then 1 -> ir_write and pc_write each high exactly 1 cycle, on the ready cycle.
//  3. lw (opcode 100011), mem_ready=1 always -> FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB.
//     reg_write only in cycle 5, with mem_to_reg=01.
//  4. beq with alu_zero=1 -> pc_write=1, pc_source=01 in BRANCH. bne with alu_zero=1 -> pc_write=0.
//  5. jal (000011) -> JUMP cycle: pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10, pc_source=10.
//  6. opcode 111111 -> TRAP, illegal=1 held 10 clks. Separately, nrst pulse low during MEM_WR -> mem_write drops at once.
//     After release, state=FETCH and illegal=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, states and select codes.
// Also used by ALU_CONTROL and the datapath so the select meanings stay in one place.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_R_EXEC   = 4'd6;
    localparam logic [3:0] ST_R_WB     = 4'd7;
    localparam logic [3:0] ST_I_EXEC   = 4'd8;
    localparam logic [3:0] ST_I_WB     = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_TRAP     = 4'd12;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    localparam logic [1:0] SRC_B_RT       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_SEXT     = 2'b10;
    localparam logic [1:0] SRC_B_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef enum logic [2:0] {
        ClsMem,
        ClsR,
        ClsBranch,
        ClsJump,
        ClsImm,
        ClsIllegal
    } instr_cls_e;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier: opcode -> class/legal, funct -> R-type legality and jr.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_cls,
    output logic       o_legal,
    output logic       o_funct_ok,
    output logic       o_is_jr
);

    instr_cls_e w_cls;

    always_comb begin
        w_cls   = ClsIllegal;
        o_legal = 1'b1;
        case (i_opcode)
            OP_LW, OP_SW:                      w_cls = ClsMem;
            OP_RTYPE:                          w_cls = ClsR;
            OP_BEQ, OP_BNE:                    w_cls = ClsBranch;
            OP_J, OP_JAL:                      w_cls = ClsJump;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_cls = ClsImm;
            default: begin
                w_cls   = ClsIllegal;
                o_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_funct_ok = 1'b0;
        case (i_funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR: o_funct_ok = 1'b1;
            default:                                      o_funct_ok = 1'b0;
        endcase
    end

    assign o_is_jr = (i_funct == FN_JR);
    assign o_cls   = w_cls;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, next-state logic and per-state select/strobe decode.
// Strobes that depend on mem_ready/alu_zero/funct are combinational so they act in the same cycle.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal,
    output logic [STATE_W-1:0] state_out
);

    logic [3:0] r_state;
    logic [3:0] w_nxt;
    logic [2:0] w_cls_raw;
    instr_cls_e w_cls;
    logic       w_legal;
    logic       w_funct_ok;
    logic       w_is_jr;

    logic       w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write, w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_alu_op, w_pc_source;

    mips_ctrl_decode u_decode (
        .i_opcode   (opcode),
        .i_funct    (funct),
        .o_cls      (w_cls_raw),
        .o_legal    (w_legal),
        .o_funct_ok (w_funct_ok),
        .o_is_jr    (w_is_jr)
    );

    assign w_cls = instr_cls_e'(w_cls_raw);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt        = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = REG_DST_RT;
        w_mem_to_reg = M2R_ALUOUT;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRC_B_RT;
        w_alu_op     = ALU_OP_ADD;
        w_pc_source  = PC_SRC_ALU;
        case (r_state)
            ST_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_nxt      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_alu_src_b = SRC_B_SEXT_SH2;
                if (!w_legal) begin
                    w_nxt = ST_TRAP;
                end else begin
                    case (w_cls)
                        ClsMem:    w_nxt = ST_MEM_ADDR;
                        ClsR:      w_nxt = ST_R_EXEC;
                        ClsBranch: w_nxt = ST_BRANCH;
                        ClsJump:   w_nxt = ST_JUMP;
                        ClsImm:    w_nxt = ST_I_EXEC;
                        default:   w_nxt = ST_TRAP;
                    endcase
                end
            end
            ST_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRC_B_SEXT;
                w_nxt       = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (mem_ready) w_nxt = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_MDR;
                w_nxt        = ST_FETCH;
            end
            ST_MEM_WR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (mem_ready) w_nxt = ST_FETCH;
            end
            ST_R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_OP_FUNCT;
                if (w_is_jr) begin
                    w_pc_source = PC_SRC_RS;
                    w_pc_write  = 1'b1;
                    w_nxt       = ST_FETCH;
                end else begin
                    w_nxt = w_funct_ok ? ST_R_WB : ST_TRAP;
                end
            end
            ST_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = REG_DST_RD;
                w_nxt       = ST_FETCH;
            end
            ST_I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRC_B_SEXT;
                w_alu_op    = ALU_OP_IMM;
                w_nxt       = ST_I_WB;
            end
            ST_I_WB: begin
                w_reg_write = 1'b1;
                w_nxt       = ST_FETCH;
            end
            ST_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_OP_SUB;
                w_pc_source = PC_SRC_ALUOUT;
                w_pc_write  = (opcode == OP_BNE) ? !alu_zero : alu_zero;
                w_nxt       = ST_FETCH;
            end
            ST_JUMP: begin
                w_pc_source = PC_SRC_JUMP;
                w_pc_write  = 1'b1;
                // PC already holds the return address from FETCH, so link writes it directly.
                if (opcode == OP_JAL) begin
                    w_reg_write  = 1'b1;
                    w_reg_dst    = REG_DST_R31;
                    w_mem_to_reg = M2R_PC;
                end
                w_nxt = ST_FETCH;
            end
            ST_TRAP: w_nxt = ST_TRAP;
            default: w_nxt = ST_FETCH;
        endcase
    end

    // Gate with nrst so nothing strobes in the cycle reset asserts, even though FETCH is state 0.
    assign pc_write   = nrst & w_pc_write;
    assign ir_write   = nrst & w_ir_write;
    assign i_or_d     = nrst & w_i_or_d;
    assign mem_read   = nrst & w_mem_read;
    assign mem_write  = nrst & w_mem_write;
    assign reg_write  = nrst & w_reg_write;
    assign alu_src_a  = nrst & w_alu_src_a;
    assign reg_dst    = nrst ? w_reg_dst    : 2'b00;
    assign mem_to_reg = nrst ? w_mem_to_reg : 2'b00;
    assign alu_src_b  = nrst ? w_alu_src_b  : 2'b00;
    assign alu_op     = nrst ? w_alu_op     : 2'b00;
    assign pc_source  = nrst ? w_pc_source  : 2'b00;
    assign illegal    = nrst & (r_state == ST_TRAP);
    assign state_out  = nrst ? STATE_W'(r_state) : '0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction cycle schedules built from the instruction rules, compared each cycle.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic [3:0] state;
    } cyc_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a, illegal;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] state_out;
    cyc_t       obs;

    int n_pass = 0;
    int n_total = 0;

    cyc_t exp_q[$];
    bit   rdy_q[$];

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal    (illegal),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state_out};

    function automatic cyc_t rec(input logic [3:0] st);
        cyc_t c;
        c = '0;
        c.state = st;
        return c;
    endfunction

    function automatic bit idle_rdy(input bit all_ready);
        return all_ready ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, from fetch to its last cycle.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                         input int wf, input int wm, input bit all_ready, input int ntrap);
        cyc_t c;
        exp_q.delete();
        rdy_q.delete();
        c = rec(ST_FETCH);
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        for (int i = 0; i < wf; i++) begin
            exp_q.push_back(c); rdy_q.push_back(1'b0);
        end
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        exp_q.push_back(c); rdy_q.push_back(1'b1);
        c = rec(ST_DECODE);
        c.alu_src_b = 2'b11;
        exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
        case (op)
            6'b100011, 6'b101011: begin
                c = rec(ST_MEM_ADDR);
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
                c = rec(op == 6'b100011 ? ST_MEM_RD : ST_MEM_WR);
                c.i_or_d = 1'b1;
                if (op == 6'b100011) c.mem_read = 1'b1;
                else c.mem_write = 1'b1;
                for (int i = 0; i < wm; i++) begin
                    exp_q.push_back(c); rdy_q.push_back(1'b0);
                end
                exp_q.push_back(c); rdy_q.push_back(1'b1);
                if (op == 6'b100011) begin
                    c = rec(ST_MEM_WB);
                    c.reg_write = 1'b1; c.mem_to_reg = 2'b01;
                    exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
                end
            end
            6'b000000: begin
                c = rec(ST_R_EXEC);
                c.alu_src_a = 1'b1; c.alu_op = 2'b10;
                if (fn == 6'b001000) begin
                    c.pc_source = 2'b11; c.pc_write = 1'b1;
                end
                exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
                    c = rec(ST_R_WB);
                    c.reg_write = 1'b1; c.reg_dst = 2'b01;
                    exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
                end else if (fn != 6'b001000) begin
                    c = rec(ST_TRAP);
                    c.illegal = 1'b1;
                    for (int i = 0; i < ntrap; i++) begin
                        exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
                    end
                end
            end
            6'b000100, 6'b000101: begin
                c = rec(ST_BRANCH);
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
                c.pc_write = (op == 6'b000100) ? zero : !zero;
                exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
            end
            6'b000010, 6'b000011: begin
                c = rec(ST_JUMP);
                c.pc_source = 2'b10; c.pc_write = 1'b1;
                if (op == 6'b000011) begin
                    c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                end
                exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
            end
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                c = rec(ST_I_EXEC);
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
                exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
                c = rec(ST_I_WB);
                c.reg_write = 1'b1;
                exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
            end
            default: begin
                c = rec(ST_TRAP);
                c.illegal = 1'b1;
                for (int i = 0; i < ntrap; i++) begin
                    exp_q.push_back(c); rdy_q.push_back(idle_rdy(all_ready));
                end
            end
        endcase
    endtask

    // Entered shortly after a rising edge with the DUT in FETCH; leaves the same way.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int wf, input int wm, input bit all_ready,
                             input int ntrap, input int max_cyc);
        int n;
        build(op, fn, zero, wf, wm, all_ready, ntrap);
        n = (max_cyc > 0 && max_cyc < exp_q.size()) ? max_cyc : exp_q.size();
        for (int k = 0; k < n; k++) begin
            opcode    = op;
            funct     = fn;
            alu_zero  = zero;
            mem_ready = rdy_q[k];
            @(negedge clk);
            n_total++;
            if (obs !== exp_q[k]) begin
                $display("FAIL %s op=%b fn=%b cyc=%0d got=%h (state %0d) exp=%h (state %0d)",
                         name, op, fn, k, obs, obs.state, exp_q[k], exp_q[k].state);
            end else begin
                n_pass++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse(input string name);
        cyc_t c;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        n_total++;
        if (obs !== cyc_t'(0)) $display("FAIL %s_outputs_in_reset got=%h exp=0", name, obs);
        else n_pass++;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        nrst = 1'b1;
        c = rec(ST_FETCH);
        c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        @(negedge clk);
        n_total++;
        if (obs !== c) $display("FAIL %s_after_release got=%h exp=%h", name, obs, c);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc_t c;
        nrst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== cyc_t'(0)) $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, obs);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        nrst = 1'b1;
        c = rec(ST_FETCH);
        c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        @(negedge clk);
        n_total++;
        if (obs !== c) $display("FAIL reset_release got=%h exp=%h", obs, c);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch_wait();
        run_instr("fetch_wait", OP_RTYPE, FN_ADD, 1'b0, 4, 0, 1'b0, 0, 0);
    endtask

    task automatic test_lw();
        run_instr("lw", OP_LW, 6'd0, 1'b0, 0, 0, 1'b1, 0, 0);
        run_instr("lw_wait", OP_LW, 6'd0, 1'b1, 1, 3, 1'b0, 0, 0);
    endtask

    task automatic test_sw();
        run_instr("sw", OP_SW, 6'd0, 1'b0, 0, 2, 1'b0, 0, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b0, 0, 0);
        run_instr("bne_not_taken", OP_BNE, 6'd0, 1'b1, 0, 0, 1'b0, 0, 0);
        run_instr("beq_not_taken", OP_BEQ, 6'd0, 1'b0, 0, 0, 1'b0, 0, 0);
        run_instr("bne_taken", OP_BNE, 6'd0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_jump();
        run_instr("jal", OP_JAL, 6'd0, 1'b0, 0, 0, 1'b0, 0, 0);
        run_instr("j", OP_J, 6'd0, 1'b0, 0, 0, 1'b0, 0, 0);
        run_instr("jr", OP_RTYPE, FN_JR, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops[11];
        logic [5:0] fns[6];
        logic [5:0] op, fn;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL,
                OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};
        fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 10)];
            fn = (op == OP_RTYPE) ? fns[$urandom_range(0, 5)] : 6'($urandom);
            run_instr("random", op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0, 0, 0);
        end
    endtask

    task automatic test_trap();
        run_instr("trap_opcode", 6'b111111, 6'd0, 1'b0, 0, 0, 1'b0, 10, 0);
        reset_pulse("trap_opcode_reset");
        run_instr("trap_funct", OP_RTYPE, 6'b111111, 1'b0, 0, 0, 1'b0, 4, 0);
        reset_pulse("trap_funct_reset");
    endtask

    task automatic test_reset_mid_write();
        // Fetch, decode, address, then three waiting cycles of the store.
        run_instr("sw_abort", OP_SW, 6'd0, 1'b0, 0, 5, 1'b0, 0, 6);
        mem_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (mem_write !== 1'b1) $display("FAIL sw_abort_pending got=%b exp=1", mem_write);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_pulse("sw_abort");
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_addi", OP_ADDI, 6'd0, 1'b0, 0, 0, 1'b1, 0, 0);
        run_instr("b2b_sw", OP_SW, 6'd0, 1'b0, 0, 0, 1'b1, 0, 0);
        run_instr("b2b_or", OP_RTYPE, FN_OR, 1'b0, 0, 0, 1'b1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_lw();
        test_sw();
        test_branch();
        test_jump();
        test_back_to_back();
        test_random();
        test_trap();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
